// File: rtl/restoring_div_if.sv
// Request/result bundle for the restoring divider: the EX stage drives the
// request side (master), the divider drives status and results (slave).
interface restoring_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        divisor_is_zero;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient_out;
  logic [31:0] remainder_out;

  modport master (
    output start, op, dividend, divisor, divisor_is_zero, flush,
    input  busy, done, quotient_out, remainder_out
  );

  modport slave (
    input  start, op, dividend, divisor, divisor_is_zero, flush,
    output busy, done, quotient_out, remainder_out
  );
endinterface

// File: rtl/restoring_div.sv
// 32-bit multi-cycle restoring divider (DIV/DIVU/MOD/MODU), one quotient bit per cycle.
// Optional macro DIV_FAST_PATH_EN: zero divisor or |dividend| < |divisor| skips CALC.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 restoring iterations on operand magnitudes
// SIGN  | sign correction, results registered
// DONE  | results valid, done held until next start/flush/rst
module restoring_div (
  input  logic            clk,
  input  logic            rst,
  restoring_div_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        sgn_q, neg_a_q, neg_b_q, zero_q;
  logic [31:0] quo_out_q, rem_out_q;

  logic        sgn_in, zero_in, fast, accept;
  logic [31:0] mag_a, mag_b;
  logic [32:0] rem_shift;
  logic [31:0] diff;
  logic        borrow;
  logic        op_kind_unused;

  // op[1] only tells the consumer which result to read; both are always produced.
  assign op_kind_unused = bus.op[1];

  always_comb begin
    sgn_in  = !bus.op[0];
    zero_in = bus.divisor_is_zero || (bus.divisor == 32'd0);
    mag_a   = (sgn_in && bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    mag_b   = (sgn_in && bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
`ifdef DIV_FAST_PATH_EN
    fast    = zero_in || (mag_a < mag_b);
`else
    fast    = 1'b0;
`endif
  end

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && bus.start && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) state_nxt = fast ? S_SIGN : S_CALC;
        S_CALC:         if (cnt == 5'd31) state_nxt = S_SIGN;
        S_SIGN:         state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      S_CALC, S_SIGN: bus.busy = 1'b1;
      S_DONE:         bus.done = 1'b1;
      default:        ;
    endcase
  end

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    borrow    = rem_shift < {1'b0, dvs_q};
    diff      = rem_shift[31:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sgn_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      zero_q    <= 1'b0;
      quo_out_q <= 32'd0;
      rem_out_q <= 32'd0;
    end else if (accept) begin
      cnt     <= 5'd0;
      sgn_q   <= sgn_in;
      neg_a_q <= sgn_in && bus.dividend[31];
      neg_b_q <= sgn_in && bus.divisor[31];
      zero_q  <= zero_in;
      // A zero divisor runs with magnitude 0 so the remainder accumulates |dividend|.
      dvs_q   <= zero_in ? 32'd0 : mag_b;
      rem_q   <= fast ? mag_a : 32'd0;
      quo_q   <= fast ? 32'd0 : mag_a;
    end else if (!bus.flush && state == S_CALC) begin
      cnt   <= cnt + 5'd1;
      rem_q <= borrow ? rem_shift[31:0] : diff;
      quo_q <= {quo_q[30:0], !borrow};
    end else if (!bus.flush && state == S_SIGN) begin
      if (zero_q)                   quo_out_q <= 32'hFFFF_FFFF;
      else if (sgn_q && (neg_a_q ^ neg_b_q)) quo_out_q <= 32'd0 - quo_q;
      else                          quo_out_q <= quo_q;
      rem_out_q <= (sgn_q && neg_a_q) ? (32'd0 - rem_q) : rem_q;
    end
  end

  assign bus.quotient_out  = quo_out_q;
  assign bus.remainder_out = rem_out_q;

endmodule
